pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline register chain: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Each cycle it decides whether every pipeline register loads, holds (stall) or injects a NOP bubble.
- It detects RAW interlocks, squashes wrong-path instructions on a redirect, freezes the whole pipe while data memory is busy, and drains the pipe on halt.
- Performance counters for stall and flush events are included.

Parameters:
- DRAIN_CYCLES, 3, number of cycles after halt_E is accepted before HALTED is entered (E, M and W retire).
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  pipeline clock; state updates on negedge CLK, same edge as the pipeline registers.
- RST  in  1  reset, asynchronous, active-low (negedge RST).
- Rs1_D  in  5  source register 1 of the instruction in D.
- Rs2_D  in  5  source register 2 of the instruction in D.
- UsesRs1_D  in  1  D instruction reads Rs1.
- UsesRs2_D  in  1  D instruction reads Rs2.
- Rdst_E  in  5  destination register in E.
- RegWrEn_E  in  1  active-low; E instruction writes Rdst_E.
- Rdst_M  in  5  destination register in M.
- RegWrEn_M  in  1  active-low; M instruction writes Rdst_M.
- Redirect_E  in  1  branch taken or jump resolved in E.
- halt_E  in  1  halt instruction in E.
- mem_busy  in  1  data memory not ready.
- PC_WEN  out  1  active-low PC load enable.
- stall_FD  out  1  IF/ID stall.
- nop_FD  out  1  IF/ID NOP insert.
- stall_DE  out  1  ID/EX stall.
- nop_DE  out  1  ID/EX NOP insert.
- WEN_EM  out  1  active-low EX/MEM load enable.
- WEN_MW  out  1  active-low MEM/WB load enable.
- halted  out  1  pipeline halted.
- stall_cnt  out  CNT_W  stall cycle count.
- flush_cnt  out  CNT_W  redirect count.

Behaviour:
- Reset (RST=0, asynchronous): state=RUN, drain counter=0, halted=0, stall_cnt=0, flush_cnt=0.
  - While RST=0 outputs are forced to: PC_WEN=1, WEN_EM=1, WEN_MW=1, all stall/nop=0.
  - Reset mid-drain or mid-freeze aborts the operation immediately.
- Hazard definition: hazard = (UsesRs1_D & Rs1_D!=0 & ((!RegWrEn_E & Rs1_D==Rdst_E) | (!RegWrEn_M & Rs1_D==Rdst_M))), OR the same term for Rs2.
  - x0 never causes a hazard.
  - W stage is not a hazard: the register file writes before it is read.
- Outputs are combinational from state and inputs. Never assert stall and nop to the same register in the same cycle.
- FSM states: RUN, FREEZE, DRAIN, HALTED.
- RUN, evaluated in priority order:
  1. mem_busy=1: freeze. PC_WEN=1, stall_FD=1, stall_DE=1, WEN_EM=1, WEN_MW=1. Next state FREEZE.
  2. halt_E=1: PC_WEN=1, stall_FD=0, nop_FD=1, nop_DE=1, WEN_EM=0, WEN_MW=0. Load drain counter with DRAIN_CYCLES-1. Next state DRAIN.
  3. Redirect_E=1: PC_WEN=0 (target loads), nop_FD=1, nop_DE=1, EX/MEM and MEM/WB load. flush_cnt+1. A coincident hazard is ignored.
  4. hazard=1: PC_WEN=1, stall_FD=1, nop_DE=1 (bubble), EX/MEM and MEM/WB load. stall_cnt+1. Re-evaluated every cycle; held until clear.
  5. Otherwise: all enables active (PC_WEN=0, WEN_EM=0, WEN_MW=0), no stall, no nop.
- FREEZE:
  - Full freeze outputs as in RUN item 1; stall_cnt+1 each cycle.
  - mem_busy=0: exit to RUN the same cycle with RUN outputs (Mealy), next state RUN.
- DRAIN:
  - PC_WEN=1, nop_FD=1, nop_DE=1, EX/MEM and MEM/WB load.
  - Counter decrements each negedge. At counter==0 the next state is HALTED.
  - mem_busy=1 during DRAIN: full freeze, counter holds.
- HALTED:
  - halted=1, all registers held: PC_WEN=1, WEN_*=1, stall_*=1.
  - Left only by reset.
- Counters increment on negedge CLK and wrap from 2^CNT_W-1 to 0 silently.

Decomposition:
- Shared package: FSM state encoding (2-bit: RUN=0, FREEZE=1, DRAIN=2, HALTED=3), active-low enable constants EN_ON=0 / EN_OFF=1, NOP instruction word 32'h13.
- One natural sub-module: hazard_detect, purely combinational. Inputs: Rs1/Rs2/uses flags, Rdst_E/M, RegWrEn_E/M. Output: hazard.
- FSM, output decode and counters stay in the top module.

Test Plan:
- Load-use: Rs1_D=5, UsesRs1_D=1, Rdst_E=5, RegWrEn_E=0 for 1 cycle, then Rdst_M=5 for the next -> PC_WEN=1, stall_FD=1, nop_DE=1 for 2 cycles, then normal; stall_cnt=2.
- x0 and disabled write: Rs1_D=0 matching Rdst_E=0; then Rs2_D=7, Rdst_E=7, RegWrEn_E=1 -> no stall, stall_cnt stays 0.
- Redirect with coincident hazard: Redirect_E=1 and hazard=1 same cycle -> PC_WEN=0, nop_FD=1, nop_DE=1, stall_FD=0; flush_cnt=1.
- Memory freeze: mem_busy=1 for 3 cycles during RUN -> PC_WEN=WEN_EM=WEN_MW=1, stall_FD=stall_DE=1 for 3 cycles, RUN outputs in the cycle mem_busy drops; stall_cnt=3.
- Halt drain: halt_E=1 -> exactly 3 negedges with E/M/W loading, then halted=1 and all enables off. mem_busy=1 for 2 cycles mid-drain extends the drain to 5 negedges.
- Reset mid-drain and counter wrap: RST low during DRAIN -> halted=0, state RUN, counters 0 immediately. With CNT_W=4, 17 hazard cycles -> stall_cnt=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding,
// active-low enable levels and the RAW source-match helper.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic EN_ON  = 1'b0;
    localparam logic EN_OFF = 1'b1;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // x0 is hardwired zero, so it can never carry a dependency.
    function automatic logic src_hazard(
        input logic       uses,
        input logic [4:0] rs,
        input logic [4:0] rdst_e,
        input logic       wren_e,
        input logic [4:0] rdst_m,
        input logic       wren_m
    );
        return uses && (rs != 5'd0) &&
               (((wren_e == EN_ON) && (rs == rdst_e)) ||
                ((wren_m == EN_ON) && (rs == rdst_m)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// RAW interlock detection for the D-stage sources against E and M writers.
// W is excluded because the register file writes before it is read.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] rdst_e,
    input  logic       wren_e,
    input  logic [4:0] rdst_m,
    input  logic       wren_m,
    output logic       hazard
);

    assign hazard = src_hazard(uses_rs1, rs1, rdst_e, wren_e, rdst_m, wren_m) ||
                    src_hazard(uses_rs2, rs2, rdst_e, wren_e, rdst_m, wren_m);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-cycle load/stall/bubble decisions for the pipeline
// registers, memory freeze, halt drain, and stall/flush event counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             UsesRs1_D,
    input  logic             UsesRs2_D,
    input  logic [4:0]       Rdst_E,
    input  logic             RegWrEn_E,
    input  logic [4:0]       Rdst_M,
    input  logic             RegWrEn_M,
    input  logic             Redirect_E,
    input  logic             halt_E,
    input  logic             mem_busy,
    output logic             PC_WEN,
    output logic             stall_FD,
    output logic             nop_FD,
    output logic             stall_DE,
    output logic             nop_DE,
    output logic             WEN_EM,
    output logic             WEN_MW,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          hazard;
    logic          stall_inc, flush_inc;

    hazard_detect u_hazard_detect (
        .rs1      (Rs1_D),
        .rs2      (Rs2_D),
        .uses_rs1 (UsesRs1_D),
        .uses_rs2 (UsesRs2_D),
        .rdst_e   (Rdst_E),
        .wren_e   (RegWrEn_E),
        .rdst_m   (Rdst_M),
        .wren_m   (RegWrEn_M),
        .hazard   (hazard)
    );

    assign halted = (state == HALTED);

    always_comb begin
        PC_WEN    = EN_OFF;
        WEN_EM    = EN_OFF;
        WEN_MW    = EN_OFF;
        stall_FD  = 1'b0;
        stall_DE  = 1'b0;
        nop_FD    = 1'b0;
        nop_DE    = 1'b0;
        state_nxt = state;
        drain_nxt = drain_cnt;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        unique case (state)
            // FREEZE with mem_busy low behaves exactly like RUN (Mealy exit).
            RUN, FREEZE: begin
                if (mem_busy) begin
                    stall_FD  = 1'b1;
                    stall_DE  = 1'b1;
                    stall_inc = 1'b1;
                    state_nxt = FREEZE;
                end else if (halt_E) begin
                    nop_FD    = 1'b1;
                    nop_DE    = 1'b1;
                    WEN_EM    = EN_ON;
                    WEN_MW    = EN_ON;
                    drain_nxt = DRAIN_LOAD;
                    state_nxt = DRAIN;
                end else if (Redirect_E) begin
                    PC_WEN    = EN_ON;
                    nop_FD    = 1'b1;
                    nop_DE    = 1'b1;
                    WEN_EM    = EN_ON;
                    WEN_MW    = EN_ON;
                    flush_inc = 1'b1;
                    state_nxt = RUN;
                end else if (hazard) begin
                    stall_FD  = 1'b1;
                    nop_DE    = 1'b1;
                    WEN_EM    = EN_ON;
                    WEN_MW    = EN_ON;
                    stall_inc = 1'b1;
                    state_nxt = RUN;
                end else begin
                    PC_WEN    = EN_ON;
                    WEN_EM    = EN_ON;
                    WEN_MW    = EN_ON;
                    state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (mem_busy) begin
                    stall_FD  = 1'b1;
                    stall_DE  = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    nop_FD = 1'b1;
                    nop_DE = 1'b1;
                    WEN_EM = EN_ON;
                    WEN_MW = EN_ON;
                    if (drain_cnt == '0) begin
                        state_nxt = HALTED;
                    end else begin
                        drain_nxt = drain_cnt - DW'(1);
                    end
                end
            end
            HALTED: begin
                stall_FD = 1'b1;
                stall_DE = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (!RST) begin
            PC_WEN   = EN_OFF;
            WEN_EM   = EN_OFF;
            WEN_MW   = EN_OFF;
            stall_FD = 1'b0;
            stall_DE = 1'b0;
            nop_FD   = 1'b0;
            nop_DE   = 1'b0;
        end
    end

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with 4-bit
// counters shares the stimulus to exercise counter wrap.
module tb_pipeline_hazard_ctrl;

    // {PC_WEN, stall_FD, nop_FD, stall_DE, nop_DE, WEN_EM, WEN_MW, halted}
    localparam logic [7:0] C_NORM  = 8'b0000_0000;
    localparam logic [7:0] C_HAZ   = 8'b1100_1000;
    localparam logic [7:0] C_FRZ   = 8'b1101_0110;
    localparam logic [7:0] C_DRN   = 8'b1010_1000;
    localparam logic [7:0] C_REDIR = 8'b0010_1000;
    localparam logic [7:0] C_HLTD  = 8'b1101_0111;
    localparam logic [7:0] C_RST   = 8'b1000_0110;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  Rs1_D, Rs2_D, Rdst_E, Rdst_M;
    logic        UsesRs1_D, UsesRs2_D, RegWrEn_E, RegWrEn_M;
    logic        Redirect_E, halt_E, mem_busy;

    logic        PC_WEN, stall_FD, nop_FD, stall_DE, nop_DE, WEN_EM, WEN_MW, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic        w4_PC_WEN, w4_stall_FD, w4_nop_FD, w4_stall_DE, w4_nop_DE;
    logic        w4_WEN_EM, w4_WEN_MW, w4_halted;
    logic [3:0]  w4_stall_cnt, w4_flush_cnt;
    logic [7:0]  ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {PC_WEN, stall_FD, nop_FD, stall_DE, nop_DE, WEN_EM, WEN_MW, halted};

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
        .UsesRs1_D(UsesRs1_D), .UsesRs2_D(UsesRs2_D),
        .Rdst_E(Rdst_E), .RegWrEn_E(RegWrEn_E), .Rdst_M(Rdst_M), .RegWrEn_M(RegWrEn_M),
        .Redirect_E(Redirect_E), .halt_E(halt_E), .mem_busy(mem_busy),
        .PC_WEN(PC_WEN), .stall_FD(stall_FD), .nop_FD(nop_FD), .stall_DE(stall_DE),
        .nop_DE(nop_DE), .WEN_EM(WEN_EM), .WEN_MW(WEN_MW), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut_w4 (
        .CLK(CLK), .RST(RST), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
        .UsesRs1_D(UsesRs1_D), .UsesRs2_D(UsesRs2_D),
        .Rdst_E(Rdst_E), .RegWrEn_E(RegWrEn_E), .Rdst_M(Rdst_M), .RegWrEn_M(RegWrEn_M),
        .Redirect_E(Redirect_E), .halt_E(halt_E), .mem_busy(mem_busy),
        .PC_WEN(w4_PC_WEN), .stall_FD(w4_stall_FD), .nop_FD(w4_nop_FD),
        .stall_DE(w4_stall_DE), .nop_DE(w4_nop_DE), .WEN_EM(w4_WEN_EM),
        .WEN_MW(w4_WEN_MW), .halted(w4_halted),
        .stall_cnt(w4_stall_cnt), .flush_cnt(w4_flush_cnt)
    );

    task automatic set_idle();
        Rs1_D = 5'd0; Rs2_D = 5'd0; UsesRs1_D = 1'b0; UsesRs2_D = 1'b0;
        Rdst_E = 5'd0; Rdst_M = 5'd0; RegWrEn_E = 1'b1; RegWrEn_M = 1'b1;
        Redirect_E = 1'b0; halt_E = 1'b0; mem_busy = 1'b0;
    endtask

    // Inputs change at posedge+1; the DUT acts on the following negedge.
    task automatic tick();
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        RST = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        RST = 1'b1;
        #1 RST = 1'b0;
        #1;
        checks++; if (ctl !== C_RST) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_RST); end
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        do_reset();
        #1;
        checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL reset_run: got %b expected %b", ctl, C_NORM); end
    endtask

    task automatic test_load_use();
        do_reset();
        Rs1_D = 5'd5; UsesRs1_D = 1'b1; Rdst_E = 5'd5; RegWrEn_E = 1'b0;
        #1;
        checks++; if (ctl !== C_HAZ) begin errors++; $display("FAIL load_use_e: got %b expected %b", ctl, C_HAZ); end
        tick();
        Rdst_E = 5'd0; RegWrEn_E = 1'b1; Rdst_M = 5'd5; RegWrEn_M = 1'b0;
        #1;
        checks++; if (ctl !== C_HAZ) begin errors++; $display("FAIL load_use_m: got %b expected %b", ctl, C_HAZ); end
        tick();
        set_idle();
        #1;
        checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL load_use_clear: got %b expected %b", ctl, C_NORM); end
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL load_use_cnt: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_x0_and_disabled();
        do_reset();
        Rs1_D = 5'd0; UsesRs1_D = 1'b1; Rdst_E = 5'd0; RegWrEn_E = 1'b0;
        #1;
        checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL x0_no_haz: got %b expected %b", ctl, C_NORM); end
        tick();
        set_idle();
        Rs2_D = 5'd7; UsesRs2_D = 1'b1; Rdst_E = 5'd7; RegWrEn_E = 1'b1;
        #1;
        checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL wr_disabled: got %b expected %b", ctl, C_NORM); end
        tick();
        set_idle();
        Rs1_D = 5'd9; UsesRs1_D = 1'b0; Rdst_M = 5'd9; RegWrEn_M = 1'b0;
        #1;
        checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL unused_src: got %b expected %b", ctl, C_NORM); end
        tick();
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL x0_cnt: got %0d expected 0", stall_cnt); end
        set_idle();
        Rs2_D = 5'd9; UsesRs2_D = 1'b1; Rdst_M = 5'd9; RegWrEn_M = 1'b0;
        #1;
        checks++; if (ctl !== C_HAZ) begin errors++; $display("FAIL rs2_m_haz: got %b expected %b", ctl, C_HAZ); end
        tick();
        set_idle();
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL rs2_cnt: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_redirect();
        do_reset();
        Redirect_E = 1'b1;
        Rs1_D = 5'd3; UsesRs1_D = 1'b1; Rdst_E = 5'd3; RegWrEn_E = 1'b0;
        #1;
        checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL redirect_ctl: got %b expected %b", ctl, C_REDIR); end
        tick();
        set_idle();
        #1;
        checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin errors++; $display("FAIL redirect_cnt: got flush %0d stall %0d expected 1 0", flush_cnt, stall_cnt); end
        checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL redirect_after: got %b expected %b", ctl, C_NORM); end
    endtask

    task automatic test_freeze();
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL freeze_%0d: got %b expected %b", i, ctl, C_FRZ); end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL freeze_exit: got %b expected %b", ctl, C_NORM); end
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL freeze_cnt: got %0d expected 3", stall_cnt); end
        tick();
        checks++; if (ctl !== C_NORM || stall_cnt !== 32'd3) begin errors++; $display("FAIL freeze_after: got %b cnt %0d expected %b cnt 3", ctl, stall_cnt, C_NORM); end
    endtask

    task automatic test_halt_drain();
        int drains;
        do_reset();
        halt_E = 1'b1;
        #1;
        checks++; if (ctl !== C_DRN) begin errors++; $display("FAIL halt_accept: got %b expected %b", ctl, C_DRN); end
        tick();
        halt_E = 1'b0;
        drains = 0;
        for (int i = 0; i < 10 && !halted; i++) begin
            if (ctl === C_DRN) drains++;
            tick();
        end
        checks++; if (drains !== 3) begin errors++; $display("FAIL drain_len: got %0d expected 3", drains); end
        checks++; if (ctl !== C_HLTD) begin errors++; $display("FAIL halted_ctl: got %b expected %b", ctl, C_HLTD); end
        Redirect_E = 1'b1;
        tick();
        tick();
        checks++; if (ctl !== C_HLTD || flush_cnt !== 32'd0) begin errors++; $display("FAIL halted_sticky: got %b flush %0d expected %b flush 0", ctl, flush_cnt, C_HLTD); end

        do_reset();
        halt_E = 1'b1;
        tick();
        halt_E = 1'b0;
        #1;
        checks++; if (ctl !== C_DRN) begin errors++; $display("FAIL drainf_0: got %b expected %b", ctl, C_DRN); end
        tick();
        mem_busy = 1'b1;
        #1;
        checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL drainf_1: got %b expected %b", ctl, C_FRZ); end
        tick();
        #1;
        checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL drainf_2: got %b expected %b", ctl, C_FRZ); end
        tick();
        mem_busy = 1'b0;
        #1;
        checks++; if (ctl !== C_DRN) begin errors++; $display("FAIL drainf_3: got %b expected %b", ctl, C_DRN); end
        tick();
        #1;
        checks++; if (ctl !== C_DRN) begin errors++; $display("FAIL drainf_4: got %b expected %b", ctl, C_DRN); end
        tick();
        checks++; if (ctl !== C_HLTD) begin errors++; $display("FAIL drainf_end: got %b expected %b", ctl, C_HLTD); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        Redirect_E = 1'b1;
        tick();
        Redirect_E = 1'b0;
        halt_E = 1'b1;
        tick();
        halt_E = 1'b0;
        #1;
        checks++; if (ctl !== C_DRN || flush_cnt !== 32'd1) begin errors++; $display("FAIL mid_drain_pre: got %b flush %0d expected %b flush 1", ctl, flush_cnt, C_DRN); end
        RST = 1'b0;
        #1;
        checks++; if (ctl !== C_RST || flush_cnt !== 32'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL mid_drain_rst: got %b flush %0d stall %0d expected %b 0 0", ctl, flush_cnt, stall_cnt, C_RST); end
        RST = 1'b1;
        #1;
        checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL mid_drain_run: got %b expected %b", ctl, C_NORM); end
        tick();
        tick();
        tick();
        checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL mid_drain_stay: got %b expected %b", ctl, C_NORM); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        Rs1_D = 5'd12; UsesRs1_D = 1'b1; Rdst_E = 5'd12; RegWrEn_E = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        set_idle();
        #1;
        checks++; if (w4_stall_cnt !== 4'd1) begin errors++; $display("FAIL wrap_w4: got %0d expected 1", w4_stall_cnt); end
        checks++; if (stall_cnt !== 32'd17) begin errors++; $display("FAIL wrap_w32: got %0d expected 17", stall_cnt); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_x0_and_disabled();
        test_redirect();
        test_freeze();
        test_halt_drain();
        test_reset_mid_drain();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
